// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the two-port ALU arbiter:
//   - 5-bit ALU opcode constants (codes above OP_SRA execute as ADD)
//   - output-slot state encoding used by alu_arbiter
//   - operand / result widths
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 5;
    localparam int SHAMT_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] OP_AND = 5'd2;
    localparam logic [OP_W-1:0] OP_OR  = 5'd3;
    localparam logic [OP_W-1:0] OP_SLL = 5'd4;
    localparam logic [OP_W-1:0] OP_SRA = 5'd5;

    // ST_EMPTY: the output register holds nothing.
    // ST_FULL : the output register holds a response owned by one port.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
// Two-way round-robin pick. A grant is only issued when the shared slot
// is free. With a single valid requester that requester wins; with both
// valid, the port named by prio wins.
// Ports:
//   valid_0, valid_1 : request valids
//   prio             : port that wins a simultaneous request
//   free             : shared slot can take a new operation this cycle
//   grant_0, grant_1 : one-hot (or zero) grant
module rr_pick2 (
    input  logic valid_0,
    input  logic valid_1,
    input  logic prio,
    input  logic free,
    output logic grant_0,
    output logic grant_1
);

    assign grant_0 = free && valid_0 && (!valid_1 || (prio == 1'b0));
    assign grant_1 = free && valid_1 && (!valid_0 || (prio == 1'b1));

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two requesters share one combinational ALU followed by a single output
// register. A request is executed in the cycle it is accepted and its
// response appears on the next cycle, held until the owning port takes it.
// A held response blocks both ports; when the owner consumes in the same
// cycle a new operation can be accepted (one operation per cycle).
//
// Handshake semantics (both directions):
//   A request transfers on a rising edge where req_valid_p && req_ready_p.
//   A response transfers on a rising edge where rsp_valid_p && rsp_ready_p.
//   req_ready_p depends only on the valids, prio, state, own and rsp_ready,
//   never on payload data. Response outputs stay stable while
//   rsp_valid_p && !rsp_ready_p.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   req_valid_p/req_ready_p : request handshake, p = 0/1
//   req_op_p, req_shamt_p   : opcode and shift amount
//   req_a_p, req_b_p        : operands
//   rsp_valid_p/rsp_ready_p : response handshake
//   rsp_result              : registered ALU result (shared)
//   rsp_ne, rsp_lt, rsp_ovf : registered A!=B, signed A<B, signed overflow
//   dbg_state, dbg_own, dbg_prio : internal state for observation
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               req_valid_0,
    output logic               req_ready_0,
    input  logic [OP_W-1:0]    req_op_0,
    input  logic [SHAMT_W-1:0] req_shamt_0,
    input  logic [DATA_W-1:0]  req_a_0,
    input  logic [DATA_W-1:0]  req_b_0,

    input  logic               req_valid_1,
    output logic               req_ready_1,
    input  logic [OP_W-1:0]    req_op_1,
    input  logic [SHAMT_W-1:0] req_shamt_1,
    input  logic [DATA_W-1:0]  req_a_1,
    input  logic [DATA_W-1:0]  req_b_1,

    output logic               rsp_valid_0,
    input  logic               rsp_ready_0,
    output logic               rsp_valid_1,
    input  logic               rsp_ready_1,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_ne,
    output logic               rsp_lt,
    output logic               rsp_ovf,

    output state_t             dbg_state,
    output logic               dbg_own,
    output logic               dbg_prio
);

    state_t              state;
    logic                own;
    logic                prio;
    logic [DATA_W-1:0]   result_q;
    logic                ne_q;
    logic                lt_q;
    logic                ovf_q;

    logic                consume;
    logic                free;
    logic                grant_0;
    logic                grant_1;
    logic                accept;

    // Selected operands and ALU outputs
    logic [OP_W-1:0]     sel_op;
    logic [SHAMT_W-1:0]  sel_shamt;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   diff;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_ne;
    logic                alu_lt;
    logic                alu_ovf;

    // The owner takes its response this cycle; frees the slot for a
    // back-to-back accept.
    assign consume = (state == ST_FULL) && (own ? rsp_ready_1 : rsp_ready_0);
    assign free    = (state == ST_EMPTY) || consume;

    rr_pick2 u_pick (
        .valid_0 (req_valid_0),
        .valid_1 (req_valid_1),
        .prio    (prio),
        .free    (free),
        .grant_0 (grant_0),
        .grant_1 (grant_1)
    );

    assign accept = grant_0 || grant_1;

    // Reset masks the handshakes so nothing is accepted or offered while
    // reset is held, even though the state registers clear only at the edge.
    assign req_ready_0 = grant_0 && !reset;
    assign req_ready_1 = grant_1 && !reset;
    assign rsp_valid_0 = (state == ST_FULL) && !own && !reset;
    assign rsp_valid_1 = (state == ST_FULL) &&  own && !reset;

    assign rsp_result = result_q;
    assign rsp_ne     = ne_q;
    assign rsp_lt     = lt_q;
    assign rsp_ovf    = ovf_q;

    assign dbg_state = state;
    assign dbg_own   = own;
    assign dbg_prio  = prio;

    // The single shared ALU, fed by the winning port's operands.
    always_comb begin
        sel_op    = grant_1 ? req_op_1    : req_op_0;
        sel_shamt = grant_1 ? req_shamt_1 : req_shamt_0;
        sel_a     = grant_1 ? req_a_1     : req_a_0;
        sel_b     = grant_1 ? req_b_1     : req_b_0;

        sum  = sel_a + sel_b;
        diff = sel_a - sel_b;

        alu_ne = (sel_a != sel_b);
        alu_lt = ($signed(sel_a) < $signed(sel_b));

        // Default covers OP_ADD and every unassigned opcode.
        alu_result = sum;
        alu_ovf    = (sel_a[DATA_W-1] == sel_b[DATA_W-1]) &&
                     (sum[DATA_W-1] != sel_a[DATA_W-1]);

        case (sel_op)
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = (sel_a[DATA_W-1] != sel_b[DATA_W-1]) &&
                             (diff[DATA_W-1] != sel_a[DATA_W-1]);
            end
            OP_AND: begin
                alu_result = sel_a & sel_b;
                alu_ovf    = 1'b0;
            end
            OP_OR: begin
                alu_result = sel_a | sel_b;
                alu_ovf    = 1'b0;
            end
            OP_SLL: begin
                alu_result = sel_a << sel_shamt;
                alu_ovf    = 1'b0;
            end
            OP_SRA: begin
                alu_result = $unsigned($signed(sel_a) >>> sel_shamt);
                alu_ovf    = 1'b0;
            end
            default: begin
                alu_result = sum;
            end
        endcase
    end

    // Slot FSM with its registered response payload.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_EMPTY;
            prio     <= PRIO_INIT;
            own      <= 1'b0;
            result_q <= '0;
            ne_q     <= 1'b0;
            lt_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state    <= ST_FULL;
                        own      <= grant_1;
                        prio     <= ~grant_1;
                        result_q <= alu_result;
                        ne_q     <= alu_ne;
                        lt_q     <= alu_lt;
                        ovf_q    <= alu_ovf;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        // Owner consumed and a new op lands in the same edge.
                        state    <= ST_FULL;
                        own      <= grant_1;
                        prio     <= ~grant_1;
                        result_q <= alu_result;
                        ne_q     <= alu_ne;
                        lt_q     <= alu_lt;
                        ovf_q    <= alu_ovf;
                    end else if (consume) begin
                        state <= ST_EMPTY;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter PRIO_INIT, default 0, meaning the port that wins the first simultaneous request after reset.
REQ-002 clock  input  1  Single clock; all state updates on its rising edge.
REQ-003 reset  input  1  Synchronous, active-high reset.
REQ-004 req_valid_0 / req_valid_1  input  1 each  Requester p presents an operation.
REQ-005 req_ready_0 / req_ready_1  output  1 each  Requester p's operation is accepted this cycle.
REQ-006 req_op_0 / req_op_1  input  5 each  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRA, 6-31 treated as ADD.
REQ-007 req_shamt_0 / req_shamt_1  input  5 each  Shift amount.
REQ-008 req_a_0, req_b_0, req_a_1, req_b_1  input  32 each  Operands.
REQ-009 rsp_valid_0 / rsp_valid_1  output  1 each  Response held for port p.
REQ-010 rsp_ready_0 / rsp_ready_1  input  1 each  Port p consumes its response.
REQ-011 rsp_result  output  32  Registered ALU result, shared by both ports.
REQ-012 rsp_ne, rsp_lt, rsp_ovf  output  1 each  Registered isNotEqual, signed isLessThan, overflow flags.

Function
REQ-013 The block SHALL share one combinational ALU instance between two requesters, with one output register stage (latency 1 cycle from accept to rsp_valid).
REQ-014 States: EMPTY (output register empty) and FULL (register holds a response owned by port `own`).
REQ-015 Handshake: a request is accepted when req_valid_p && req_ready_p; a response is consumed when rsp_valid_p && rsp_ready_p.
REQ-016 The slot is free when state is EMPTY, or state is FULL and the owner consumes this cycle (back-to-back, 1 op/cycle throughput).
REQ-017 At most one req_ready SHALL be high per cycle, and only when the slot is free and that port's req_valid is high.
REQ-018 Arbitration: one valid port wins; both valid -> port `prio` wins.
REQ-019 After each accept by port p, prio SHALL become the other port; prio is unchanged in cycles with no accept.
REQ-020 On accept: result/flags of the winner's operands are latched, own := winner, state := FULL.
REQ-021 On consume with no accept: state := EMPTY; register contents are don't-care but rsp_valid_* SHALL be 0.
REQ-022 rsp_valid_p = (state==FULL) && (own==p); the other port's rsp_valid SHALL be 0.
REQ-023 Response outputs SHALL remain stable while rsp_valid_p && !rsp_ready_p.
REQ-024 Arithmetic: ADD/SUB are 32-bit wrap-around; overflow = signed overflow of the selected ADD/SUB; overflow = 0 for AND/OR/SLL/SRA.
REQ-025 rsp_ne = (A != B); rsp_lt = signed(A) < signed(B), both evaluated for every opcode.
REQ-026 SRA is arithmetic and SLL is logical, both by shamt bits 0-31.
REQ-027 req_ready_p SHALL NOT depend combinationally on req_valid of the other port's payload data, only on the valids, prio, state, own and rsp_ready.
REQ-028 A response that is not consumed SHALL block both ports (no bypass).

Reset
REQ-029 While reset is high at a clock edge: state := EMPTY, prio := PRIO_INIT, own := 0, result/flags := 0.
REQ-030 During reset cycles, req_ready_* and rsp_valid_* SHALL be 0; any in-flight response is discarded.

Structure
REQ-031 Opcode constants (ADD..SRA) and state encoding SHALL live in a shared package alu_pkg.
REQ-032 Round-robin pick logic SHALL be one sub-module, rr_pick2 (inputs: two valids, prio, free; outputs: two grants).
REQ-033 The ALU function SHALL be a single combinational block inside alu_arbiter, with no second ALU copy.

Verification
REQ-034 Port 0 ADD 0x7FFFFFFF+1, rsp_ready_0=1 -> next cycle rsp_valid_0=1, result 0x80000000, ovf=1, lt=0, ne=1.
REQ-035 Both valid every cycle, both rsp_ready=1, PRIO_INIT=0 -> grants alternate 0,1,0,1; one response per cycle.
REQ-036 Port 1 SUB 5-7, rsp_ready_1=0 for 3 cycles -> rsp_valid_1 held, result 0xFFFFFFFE stable, req_ready_* all 0, then consumed.
REQ-037 Port 0 SRA 0x80000000 by 4, then SLL 0x1 by 31 -> 0xF8000000, then 0x80000000, ovf=0.
REQ-038 Reset asserted while FULL -> next cycle rsp_valid_*=0, prio=PRIO_INIT; first simultaneous request goes to PRIO_INIT.
REQ-039 Opcode 9 with A=3, B=4 -> result 7 (treated as ADD).
